servo_loop_sequencer: RTL and testbench

SERVO_LOOP_SEQUENCER -- requirements
Module: servo_loop_sequencer

---
 rtl/servo_loop_sequencer.sv | 175 +++++++++++++++++
 tb/tb_servo_loop_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_loop_sequencer.sv
// Servo loop sequencer: waits for a PWM measurement trigger and an ADC frame, runs the
// servo compute core, then registers clamped duties (or safe duties on overcurrent).
module servo_loop_sequencer #(
    parameter int DUTY_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      core_en,
    input  logic [DUTY_WIDTH-1:0]     half_period,
    input  logic                      measurement_trigger,
    input  logic                      adc_valid,
    input  logic [DUTY_WIDTH-1:0]     current_0,
    input  logic [DUTY_WIDTH-1:0]     current_1,
    input  logic [DUTY_WIDTH-1:0]     current_2,
    input  logic [DUTY_WIDTH-1:0]     current_3,
    input  logic [4*DUTY_WIDTH-1:0]   current_max,
    input  logic                      fault_clear,
    output logic                      ap_start,
    input  logic                      ap_done,
    input  logic [63:0]               ap_return,
    output logic [DUTY_WIDTH-1:0]     d0,
    output logic [DUTY_WIDTH-1:0]     d1,
    output logic [DUTY_WIDTH-1:0]     d2,
    output logic [DUTY_WIDTH-1:0]     d3,
    output logic                      duty_update,
    output logic                      busy,
    output logic [3:0]                fault,
    output logic                      timeout_err,
    output logic [7:0]                overrun_cnt
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADC  = 2'd1,
        RUN       = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  start_accept;
    logic                  done_accept;
    logic                  timeout_hit;
    logic [3:0]            fault_set;
    logic [3:0]            fault_next;
    logic [DUTY_WIDTH-1:0] duty_q  [4];
    logic [DUTY_WIDTH-1:0] current [4];
    logic [DUTY_WIDTH-1:0] limit   [4];
    logic [DUTY_WIDTH-1:0] result  [4];
    logic                  unused_ap_return;

    function automatic logic [DUTY_WIDTH-1:0] clamp_duty(
        input logic [DUTY_WIDTH-1:0] raw,
        input logic [DUTY_WIDTH-1:0] ceiling
    );
        return (raw > ceiling) ? ceiling : raw;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    assign current[0] = current_0;
    assign current[1] = current_1;
    assign current[2] = current_2;
    assign current[3] = current_3;

    // Only the low DUTY_WIDTH bits of each 16-bit return field carry a duty.
    assign unused_ap_return = ^ap_return;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            limit[n]     = current_max[DUTY_WIDTH*n +: DUTY_WIDTH];
            result[n]    = ap_return[16*n +: DUTY_WIDTH];
            fault_set[n] = adc_valid && (current[n] > limit[n]);
        end
        fault_next = (fault & ~{4{fault_clear}}) | fault_set;
    end

    always_comb begin
        state_next   = state;
        ap_start     = 1'b0;
        start_accept = 1'b0;
        done_accept  = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (measurement_trigger) begin
                    start_accept = 1'b1;
                    state_next   = WAIT_ADC;
                end
            end
            WAIT_ADC: begin
                if (adc_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ap_start   = 1'b1;
                state_next = WAIT_DONE;
                if (ap_done) begin
                    done_accept = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                ap_start = 1'b1;
                if (ap_done) begin
                    done_accept = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Timeout beats a simultaneous ap_done; disable beats everything.
        if (state != IDLE && tmo_cnt == TIMEOUT_LIMIT) begin
            timeout_hit = 1'b1;
            done_accept = 1'b0;
            state_next  = IDLE;
        end
        if (!core_en) begin
            start_accept = 1'b0;
            done_accept  = 1'b0;
            timeout_hit  = 1'b0;
            state_next   = IDLE;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            fault       <= '0;
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
            duty_update <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                duty_q[n] <= '0;
            end
        end else begin
            state       <= state_next;
            fault       <= fault_next;
            timeout_err <= (timeout_err & ~fault_clear) | timeout_hit;
            duty_update <= done_accept;
            if (start_accept) begin
                tmo_cnt <= '0;
            end else if (busy && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (busy && measurement_trigger) begin
                overrun_cnt <= sat_inc8(overrun_cnt);
            end
            // A faulted channel keeps the safe duty and drops compute results.
            for (int n = 0; n < 4; n++) begin
                if (fault_next[n]) begin
                    duty_q[n] <= half_period >> 1;
                end else if (done_accept && !fault[n]) begin
                    duty_q[n] <= clamp_duty(result[n], half_period);
                end
            end
        end
    end

    assign d0 = duty_q[0];
    assign d1 = duty_q[1];
    assign d2 = duty_q[2];
    assign d3 = duty_q[3];

endmodule

// File: tb/tb_servo_loop_sequencer.sv
// Bench for servo_loop_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_servo_loop_sequencer;

    localparam int TMO = 31;

    logic        clk = 1'b0;
    logic        reset, core_en, measurement_trigger, adc_valid, fault_clear, ap_done;
    logic [11:0] half_period, current_0, current_1, current_2, current_3;
    logic [47:0] current_max;
    logic [63:0] ap_return;
    logic        ap_start, duty_update, busy, timeout_err;
    logic [11:0] d0, d1, d2, d3;
    logic [3:0]  fault;
    logic [7:0]  overrun_cnt;

    // Model: an abstract "cycle in progress" flag plus whether the ADC frame arrived.
    bit       m_active, m_adc, m_upd, m_terr;
    int       m_elapsed, m_ovr;
    int       m_d [4];
    bit [3:0] m_fault;

    int n_cmp = 0;
    int n_fail = 0;

    servo_loop_sequencer #(.DUTY_WIDTH(12), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .core_en(core_en), .half_period(half_period),
        .measurement_trigger(measurement_trigger), .adc_valid(adc_valid),
        .current_0(current_0), .current_1(current_1), .current_2(current_2),
        .current_3(current_3), .current_max(current_max), .fault_clear(fault_clear),
        .ap_start(ap_start), .ap_done(ap_done), .ap_return(ap_return),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .duty_update(duty_update), .busy(busy),
        .fault(fault), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic int cur(input int n);
        case (n)
            0: return int'(current_0);
            1: return int'(current_1);
            2: return int'(current_2);
            default: return int'(current_3);
        endcase
    endfunction

    task automatic model_step();
        bit [3:0] set_v, old_f;
        bit       accept, tmo;
        int       raw, hp;
        if (reset) begin
            m_active = 0; m_adc = 0; m_elapsed = 0; m_upd = 0;
            m_fault = '0; m_terr = 0; m_ovr = 0;
            for (int n = 0; n < 4; n++) m_d[n] = 0;
        end else begin
            hp = int'(half_period);
            old_f = m_fault;
            accept = 0;
            tmo = 0;
            for (int n = 0; n < 4; n++)
                set_v[n] = adc_valid && (cur(n) > int'(current_max[12*n +: 12]));
            if (m_active && measurement_trigger && m_ovr < 255) m_ovr++;
            if (!core_en) begin
                m_active = 0;
            end else if (!m_active) begin
                if (measurement_trigger) begin
                    m_active = 1; m_adc = 0; m_elapsed = 0;
                end
            end else if (m_elapsed == TMO) begin
                tmo = 1; m_active = 0;
            end else begin
                if (m_adc && ap_done) begin
                    accept = 1; m_active = 0;
                end else if (!m_adc && adc_valid) begin
                    m_adc = 1;
                end
                m_elapsed++;
            end
            m_fault = (old_f & ~{4{fault_clear}}) | set_v;
            m_terr = (m_terr && !fault_clear) || tmo;
            for (int n = 0; n < 4; n++) begin
                if (m_fault[n]) begin
                    m_d[n] = hp / 2;
                end else if (accept && !old_f[n]) begin
                    raw = int'(ap_return[16*n +: 12]);
                    m_d[n] = (raw > hp) ? hp : raw;
                end
            end
            m_upd = accept;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("busy", int'(busy), int'(m_active));
        chk("ap_start", int'(ap_start), int'(m_active && m_adc));
        chk("duty_update", int'(duty_update), int'(m_upd));
        chk("d0", int'(d0), m_d[0]);
        chk("d1", int'(d1), m_d[1]);
        chk("d2", int'(d2), m_d[2]);
        chk("d3", int'(d3), m_d[3]);
        chk("fault", int'(fault), int'(m_fault));
        chk("timeout_err", int'(timeout_err), int'(m_terr));
        chk("overrun_cnt", int'(overrun_cnt), m_ovr);
    endtask

    // One clock: model sees the same inputs as the DUT, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_ret(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
        ap_return = {4'h0, d, 4'h0, c, 4'h0, b, 4'h0, a};
    endtask

    initial begin
        reset = 1; core_en = 0; measurement_trigger = 0; adc_valid = 0;
        fault_clear = 0; ap_done = 0; half_period = 12'd1000;
        current_0 = 0; current_1 = 0; current_2 = 0; current_3 = 0;
        current_max = {4{12'hFFF}}; ap_return = '0;
        tick(); tick();
        chk("rst_d0", int'(d0), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);
        reset = 0; core_en = 1;
        tick();

        // Nominal cycle: trigger t0, adc t0+5, done t0+20.
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        repeat (4) tick();
        adc_valid = 1; tick(); adc_valid = 0;
        chk("nom_start_t6", int'(ap_start), 1);
        repeat (14) tick();
        chk("nom_start_t20", int'(ap_start), 1);
        ap_done = 1; set_ret(12'd100, 12'd200, 12'd300, 12'd400); tick(); ap_done = 0;
        chk("nom_d0", int'(d0), 100);
        chk("nom_d1", int'(d1), 200);
        chk("nom_d2", int'(d2), 300);
        chk("nom_d3", int'(d3), 400);
        chk("nom_update", int'(duty_update), 1);
        chk("nom_busy", int'(busy), 0);
        chk("nom_start_t21", int'(ap_start), 0);
        tick();
        chk("nom_update_pulse", int'(duty_update), 0);

        // Clamp with done taken in RUN.
        half_period = 12'd800;
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        adc_valid = 1; tick(); adc_valid = 0;
        ap_done = 1; set_ret(12'hFFF, 12'd50, 12'd801, 12'd800); tick(); ap_done = 0;
        chk("clamp_d0", int'(d0), 800);
        chk("clamp_d1", int'(d1), 50);
        chk("clamp_d2", int'(d2), 800);
        chk("clamp_d3", int'(d3), 800);

        // Overcurrent on channel 2, clear racing a repeat overcurrent.
        current_max = {12'hFFF, 12'h800, 12'hFFF, 12'hFFF};
        current_2 = 12'h900; adc_valid = 1; tick(); adc_valid = 0;
        chk("oc_fault", int'(fault), 4);
        chk("oc_d2_safe", int'(d2), 400);
        fault_clear = 1; adc_valid = 1; tick(); adc_valid = 0;
        chk("oc_set_wins", int'(fault), 4);
        tick(); fault_clear = 0; current_2 = 0;
        chk("oc_cleared", int'(fault), 0);
        chk("oc_d2_held", int'(d2), 400);

        // Timeout: no ap_done, TMO+1 busy cycles then IDLE.
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        adc_valid = 1; tick(); adc_valid = 0;
        repeat (TMO - 1) tick();
        chk("tmo_busy_last", int'(busy), 1);
        chk("tmo_start_last", int'(ap_start), 1);
        tick();
        chk("tmo_err", int'(timeout_err), 1);
        chk("tmo_start_off", int'(ap_start), 0);
        chk("tmo_idle", int'(busy), 0);
        chk("tmo_d0", int'(d0), 800);
        chk("tmo_d1", int'(d1), 50);
        chk("tmo_d2", int'(d2), 400);
        chk("tmo_d3", int'(d3), 800);
        fault_clear = 1; tick(); fault_clear = 0;
        chk("tmo_clear", int'(timeout_err), 0);

        // Overruns: three, then saturation.
        measurement_trigger = 1; tick();
        repeat (3) tick();
        measurement_trigger = 0;
        chk("ovr_3", int'(overrun_cnt), 3);
        measurement_trigger = 1; repeat (320) tick(); measurement_trigger = 0;
        chk("ovr_sat", int'(overrun_cnt), 255);
        core_en = 0; tick(); core_en = 1;
        fault_clear = 1; tick(); fault_clear = 0;

        // Reset during WAIT_DONE, then a late ap_done.
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        adc_valid = 1; tick(); adc_valid = 0;
        tick(); tick();
        chk("rstwd_start", int'(ap_start), 1);
        reset = 1; tick(); reset = 0;
        chk("rstwd_start_off", int'(ap_start), 0);
        ap_done = 1; set_ret(12'd111, 12'd222, 12'd333, 12'd444); tick(); ap_done = 0;
        chk("rstwd_d0", int'(d0), 0);
        chk("rstwd_update", int'(duty_update), 0);

        // core_en drop during WAIT_DONE, then a late ap_done.
        half_period = 12'd1000;
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        adc_valid = 1; tick(); adc_valid = 0;
        ap_done = 1; set_ret(12'd10, 12'd20, 12'd30, 12'd40); tick(); ap_done = 0;
        measurement_trigger = 1; tick(); measurement_trigger = 0;
        adc_valid = 1; tick(); adc_valid = 0;
        tick();
        core_en = 0; tick();
        chk("en_start_off", int'(ap_start), 0);
        chk("en_idle", int'(busy), 0);
        core_en = 1; ap_done = 1; set_ret(12'd555, 12'd555, 12'd555, 12'd555); tick(); ap_done = 0;
        chk("en_d0", int'(d0), 10);
        chk("en_d3", int'(d3), 40);
        chk("en_update", int'(duty_update), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            core_en = ($urandom_range(0, 49) != 0);
            measurement_trigger = ($urandom_range(0, 9) == 0);
            adc_valid = ($urandom_range(0, 7) == 0);
            ap_done = ($urandom_range(0, 5) == 0);
            fault_clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) half_period = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 99) == 0)
                for (int n = 0; n < 4; n++) current_max[12*n +: 12] = 12'($urandom_range(12'hC00, 12'hFFF));
            current_0 = 12'($urandom); current_1 = 12'($urandom);
            current_2 = 12'($urandom); current_3 = 12'($urandom);
            ap_return = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
